apb_slave_mem: RTL

Parametrised APB4 completer backed by a flop-based register memory. It generalises the team's first APB slave in data width, depth and wait-state count, and adds explicit address-range and alignment error checking. It sits on the APB fabric as a generic scratch/CSR target and serves as the default DUT for the APB UVC.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_mem_array.sv | 60 ++++++
 rtl/apb_slave_mem.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB completer types and sizing helpers used by apb_slave_mem
// and its memory array.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_t;

    localparam int unsigned APB_MAX_WAIT = 15;

    function automatic int unsigned apb_idx_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_WIDTH flop memory with a byte-enable write port, a registered
// read port (load or clear-to-zero) and synchronous clear on reset.
module apb_mem_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned IDX_W      = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic                    re,
    input  logic                    rclr,
    input  logic [IDX_W-1:0]        ridx,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (wbe[b]) begin
                    mem_d[widx][b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
        end
    end

    // An erroring read returns zero rather than the addressed word.
    always_comb begin
        rdata_d = rdata_q;
        if (rclr) begin
            rdata_d = '0;
        end else if (re) begin
            rdata_d = mem_q[ridx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// Parametrised APB4 completer over a flop memory with wait states and
// range/alignment error checking. Optional byte strobes: APB_SLAVE_MEM_PSTRB_EN.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [2:0]              PPROT,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_SLAVE_MEM_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int          LSB   = $clog2(BYTES);
    localparam int unsigned IDX_W = apb_idx_w(DEPTH);
    localparam int unsigned CNT_W = $clog2(APB_MAX_WAIT + 1);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH * BYTES);

    apb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wr_q, wr_d;
    logic             err_q, err_d;
    logic             pready_q, pready_d;
    logic             pslverr_q, pslverr_d;

    logic             range_err;
    logic             align_err;
    logic             mem_we;
    logic             rd_load;
    logic [BYTES-1:0] wr_be;
    logic             unused_pprot;

    assign unused_pprot = ^PPROT;
    assign range_err    = ({1'b0, PADDR} >= ADDR_LIMIT);

    generate
        if (LSB == 0) begin : g_no_align
            assign align_err = 1'b0;
        end else begin : g_align
            assign align_err = |PADDR[LSB-1:0];
        end
    endgenerate

`ifdef APB_SLAVE_MEM_PSTRB_EN
    assign wr_be = PSTRB;
`else
    assign wr_be = '1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    idx_d   = PADDR[LSB +: IDX_W];
                    wr_d    = PWRITE;
                    err_d   = range_err | align_err;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (PENABLE) begin
                    state_d = IDLE;
                    mem_we  = wr_q & ~err_q;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered, so they are derived from next-state values;
        // the read port loads on the edge that first raises PREADY.
        pready_d  = (state_d == ACCESS) && (cnt_d == '0);
        pslverr_d = pready_d & err_d;
        rd_load   = pready_d & ~pready_q & ~wr_d;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (mem_we),
        .widx  (idx_q),
        .wdata (PWDATA),
        .wbe   (wr_be),
        .re    (rd_load & ~err_d),
        .rclr  (rd_load & err_d),
        .ridx  (idx_d),
        .rdata (PRDATA)
    );

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule
